bus_interconnect: RTL and testbench
===================================

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting bus masters (1..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 5, number of memory-mapped slaves (1..16).
REQ-003 SHALL have parameter SLAVE_BASE, default {32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0100_0000}, NUM_SLAVES x 32 region bases.
REQ-004 SHALL have parameter SLAVE_MASK, default {32'hFFFF_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFF00_0000}, NUM_SLAVES x 32 compare masks.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum BUSY cycles before fault; 0 disables the timeout.
REQ-006 SHALL have ports: clk  in  1  clock; reset  in  1  reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have master-side ports: m_address_in in NMx32; m_read_in in NM; m_write_in in NM; m_write_mask_in in NMx4; m_write_value_in in NMx32; m_read_value_out out NMx32; m_ready_out out NM; m_fault_out out NM.
REQ-008 SHALL have slave-side ports: address_out out 32; read_out out 1; write_mask_out out 4; write_value_out out 32; sel_out out NS (one-hot); s_read_value_in in NSx32; s_ready_in in NS.

Function
REQ-009 SHALL implement FSM states IDLE and BUSY.
REQ-010 SHALL, in IDLE, grant the requesting master (read|write) found first searching round-robin from pointer rr_ptr, register the grant, and enter BUSY next cycle; no request keeps IDLE.
REQ-011 SHALL, in BUSY, drive address_out, write_mask_out, write_value_out from the granted master; read_out = read & ~write; write_mask_out = 0 when write is low.
REQ-012 SHALL decode address as hit[i] = ((address & SLAVE_MASK[i]) == SLAVE_BASE[i]); lowest hit index wins; sel_out one-hot in BUSY, zero in IDLE.
REQ-013 SHALL complete the transfer in the first BUSY cycle where s_ready_in of the selected slave is 1: m_ready_out[grant]=1, m_read_value_out[grant]=s_read_value_in[sel], return to IDLE, rr_ptr = grant+1 mod NUM_MASTERS.
REQ-014 SHALL, when no slave hits, assert m_ready_out[grant] and m_fault_out[grant] in the first BUSY cycle, read value 0, then complete as REQ-013.
REQ-015 SHALL count BUSY cycles; on the cycle the count equals TIMEOUT_CYCLES with no ready, assert ready+fault to the granted master and complete as REQ-013.
REQ-016 SHALL hold m_read_value_out, m_ready_out, m_fault_out at 0 for every non-granted master and in IDLE.
REQ-017 SHALL require masters to hold request and payload stable until ready; a request dropped mid-BUSY is not aborted (slave still completes).
REQ-018 SHALL give minimum latency 2 cycles (request cycle to ready cycle) for a zero-wait slave.
REQ-019 SHALL ignore s_ready_in from non-selected slaves.
REQ-020 SHALL, with NUM_MASTERS=1, grant master 0 always, rr_ptr stays 0.

Reset
REQ-021 SHALL, on reset, force IDLE, rr_ptr=0, timeout count=0, grant=0; all outputs 0 the following cycle.
REQ-022 SHALL abandon any BUSY transfer on reset with no ready or fault issued.

Structure
REQ-023 SHALL place the state enum (IDLE/BUSY) and a slave-region typedef (base, mask) in shared package bus_pkg.
REQ-024 SHALL instantiate one sub-module rr_arbiter (NUM_MASTERS request vector, pointer in, one-hot grant + index out, combinational).
REQ-025 SHALL keep the timeout counter width $clog2(TIMEOUT_CYCLES+1), minimum 1.

Verification
REQ-026 SHALL test: master 0 reads 32'h0000_0010, slave 0 ready next cycle -> ready at cycle 2, read value from slave 0, fault 0.
REQ-027 SHALL test: masters 0 and 1 request together from reset -> master 0 served first, master 1 next; repeat -> alternation 0,1,0,1.
REQ-028 SHALL test: access 32'h0400_0000 (unmapped) -> ready+fault in first BUSY cycle, read value 0, no sel_out bit.
REQ-029 SHALL test: TIMEOUT_CYCLES=4, slave never ready -> ready+fault on 4th BUSY cycle, FSM back to IDLE.
REQ-030 SHALL test: reset asserted in BUSY -> no ready/fault, sel_out 0, next request granted to master 0.
REQ-031 SHALL test: write with mask 4'b0001 value 32'hA5 to 32'h0001_0000 -> sel_out bit 1, write_mask_out 4'b0001, read_out 0.

Source files
------------

// File: rtl/bus_interconnect_pkg.sv
// Shared types for the bus interconnect: FSM state encoding and slave address regions.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;
  } slave_region_t;

  function automatic logic region_hit(logic [ADDR_W-1:0] addr, slave_region_t region);
    return (addr & region.mask) == region.base;
  endfunction

endpackage

// File: rtl/bus_interconnect_if.sv
// Bus bundle between N masters, the interconnect and M slaves.
// 'master' is the view of everything around the interconnect; 'slave' is the interconnect itself.
interface bus_interconnect_if
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5
) ();

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_address_in;
  logic [NUM_MASTERS-1:0]             m_read_in;
  logic [NUM_MASTERS-1:0]             m_write_in;
  logic [NUM_MASTERS-1:0][STRB_W-1:0] m_write_mask_in;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_write_value_in;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_read_value_out;
  logic [NUM_MASTERS-1:0]             m_ready_out;
  logic [NUM_MASTERS-1:0]             m_fault_out;

  logic [ADDR_W-1:0]                  address_out;
  logic                               read_out;
  logic [STRB_W-1:0]                  write_mask_out;
  logic [DATA_W-1:0]                  write_value_out;
  logic [NUM_SLAVES-1:0]              sel_out;
  logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_read_value_in;
  logic [NUM_SLAVES-1:0]              s_ready_in;

  modport master (
    output m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
    output s_read_value_in, s_ready_in,
    input  m_read_value_out, m_ready_out, m_fault_out,
    input  address_out, read_out, write_mask_out, write_value_out, sel_out
  );

  modport slave (
    input  m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
    input  s_read_value_in, s_ready_in,
    output m_read_value_out, m_ready_out, m_fault_out,
    output address_out, read_out, write_mask_out, write_value_out, sel_out
  );

endinterface

// File: rtl/bus_interconnect_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan offsets from far to near so the closest requester to ptr is written last.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (req[cand]) begin
        grant_oh       = '0;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// N-master to M-slave shared-bus interconnect with round-robin arbitration,
// address decode, unmapped-address fault and BUSY timeout.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0100_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
    {32'hFFFF_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFF00_0000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  bus_interconnect_if.slave bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  bus_state_e       state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] grant_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;

  logic [NUM_MASTERS-1:0] req_vec;
  logic [NUM_MASTERS-1:0] arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       next_ptr;

  logic [ADDR_W-1:0]     gnt_addr;
  logic                  gnt_rd;
  logic                  gnt_wr;
  logic [NUM_SLAVES-1:0] hit_vec;
  logic [SEL_W-1:0]      sel_idx;
  logic                  any_hit;
  logic                  busy;
  logic                  slave_rdy;
  logic                  tmo_hit;
  logic                  xfer_done;
  logic                  xfer_fault;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
    assign req_vec[gi] = bus.m_read_in[gi] | bus.m_write_in[gi];
  end

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req       (req_vec),
    .ptr       (rr_ptr_reg),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  assign gnt_addr = bus.m_address_in[grant_reg];
  assign gnt_rd   = bus.m_read_in[grant_reg];
  assign gnt_wr   = bus.m_write_in[grant_reg];

  // Region 0 is the leftmost entry of the base/mask concatenations.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
    localparam slave_region_t REGION = '{
      base: SLAVE_BASE[(NUM_SLAVES-1-gi)*32 +: 32],
      mask: SLAVE_MASK[(NUM_SLAVES-1-gi)*32 +: 32]
    };
    assign hit_vec[gi] = region_hit(gnt_addr, REGION);
  end

  always_comb begin
    sel_idx = '0;
    any_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_idx = SEL_W'(i);
        any_hit = 1'b1;
      end
    end
  end

  assign busy       = (state_reg == ST_BUSY);
  assign slave_rdy  = any_hit & bus.s_ready_in[sel_idx];
  assign tmo_hit    = TMO_EN && (tmo_cnt_reg == TMO_LIMIT);
  assign xfer_done  = busy & (~any_hit | slave_rdy | tmo_hit);
  assign xfer_fault = busy & (~any_hit | (tmo_hit & ~slave_rdy));
  assign next_ptr   = (grant_reg == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_reg + IDX_W'(1);

  always_comb begin
    bus.address_out      = '0;
    bus.read_out         = 1'b0;
    bus.write_mask_out   = '0;
    bus.write_value_out  = '0;
    bus.sel_out          = '0;
    bus.m_ready_out      = '0;
    bus.m_fault_out      = '0;
    bus.m_read_value_out = '0;
    if (busy) begin
      bus.address_out     = gnt_addr;
      bus.read_out        = gnt_rd & ~gnt_wr;
      bus.write_mask_out  = gnt_wr ? bus.m_write_mask_in[grant_reg] : '0;
      bus.write_value_out = bus.m_write_value_in[grant_reg];
      if (any_hit) begin
        bus.sel_out = NUM_SLAVES'(1) << sel_idx;
      end
      bus.m_ready_out[grant_reg] = xfer_done;
      bus.m_fault_out[grant_reg] = xfer_fault;
      if (slave_rdy) begin
        bus.m_read_value_out[grant_reg] = bus.s_read_value_in[sel_idx];
      end
    end
  end

  // tmo_cnt_reg holds the 1-based index of the current BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      grant_reg   <= '0;
      tmo_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|arb_oh) begin
            grant_reg   <= arb_idx;
            tmo_cnt_reg <= TMO_W'(1);
            state_reg   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (xfer_done) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= next_ptr;
            tmo_cnt_reg <= '0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect: expected completions are queued at issue time
// and compared when a master sees ready.
module tb_bus_interconnect;

    localparam int NM  = 2;
    localparam int NS  = 5;
    localparam int TMO = 4;

    typedef struct {
        int          master;
        logic [31:0] rdata;
        logic        fault;
        logic [NS-1:0] sel;
        logic        rd;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   failures = 0;
    int   cyc = 0;
    int   slave_wait = 0;
    int   sel_age = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bus_interconnect_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus ();

    bus_interconnect #(
        .NUM_MASTERS    (NM),
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] slave_data(int s, logic [31:0] a);
        logic [3:0] sn;
        sn = s[3:0];
        return {4'hC, sn, 8'h00, a[15:0]};
    endfunction

    // Slave model: the selected slave answers after slave_wait BUSY cycles (never if negative);
    // every unselected slave holds ready high.
    always @(posedge clk) sel_age <= (|bus.sel_out) ? sel_age + 1 : 0;

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            bus.s_read_value_in[s] = slave_data(s, bus.address_out);
            bus.s_ready_in[s]      = bus.sel_out[s] ? (slave_wait >= 0 && sel_age >= slave_wait) : 1'b1;
        end
    end

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_masters();
        for (int m = 0; m < NM; m++) begin
            bus.m_address_in[m]     = '0;
            bus.m_read_in[m]        = 1'b0;
            bus.m_write_in[m]       = 1'b0;
            bus.m_write_mask_in[m]  = '0;
            bus.m_write_value_in[m] = '0;
        end
    endtask

    task automatic issue(int m, logic rd, logic wr, logic [31:0] addr, logic [3:0] mask,
                         logic [31:0] wdata, int sidx, logic fault, int lat);
        exp_t e;
        bus.m_address_in[m]     = addr;
        bus.m_read_in[m]        = rd;
        bus.m_write_in[m]       = wr;
        bus.m_write_mask_in[m]  = mask;
        bus.m_write_value_in[m] = wdata;
        e.master = m;
        e.fault  = fault;
        e.sel    = (sidx >= 0) ? (NS'(1) << sidx) : '0;
        e.rdata  = fault ? 32'h0 : slave_data(sidx, addr);
        e.rd     = rd & ~wr;
        e.mask   = wr ? mask : 4'h0;
        e.addr   = addr;
        e.wdata  = wdata;
        e.lat    = lat;
        e.start  = cyc;
        sb_q.push_back(e);
    endtask

    // One clock: sample at negedge, score any completion, then let the finished master drop its request.
    task automatic tick();
        exp_t          e;
        logic [NM-1:0] drop;
        logic [NM-1:0] oh;
        drop = '0;
        @(negedge clk);
        if (|bus.m_ready_out) begin
            drop = bus.m_ready_out;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_ready", 32'(bus.m_ready_out), 32'h0);
            end else begin
                e = sb_q.pop_front();
                oh = '0;
                oh[e.master] = 1'b1;
                check_eq("ready_vec", 32'(bus.m_ready_out), 32'(oh));
                check_eq("fault_vec", 32'(bus.m_fault_out), e.fault ? 32'(oh) : 32'h0);
                check_eq("rdata", bus.m_read_value_out[e.master], e.rdata);
                for (int j = 0; j < NM; j++) begin
                    if (j != e.master) check_eq("other_rdata", bus.m_read_value_out[j], 32'h0);
                end
                check_eq("sel", 32'(bus.sel_out), 32'(e.sel));
                check_eq("address", bus.address_out, e.addr);
                check_eq("read_out", 32'(bus.read_out), 32'(e.rd));
                check_eq("wmask", 32'(bus.write_mask_out), 32'(e.mask));
                check_eq("wdata", bus.write_value_out, e.wdata);
                check_eq("latency", 32'(cyc - e.start + 1), 32'(e.lat));
                $display("[TB] xfer m%0d addr %h rdata %h fault %0b latency %0d",
                         e.master, bus.address_out, bus.m_read_value_out[e.master],
                         bus.m_fault_out[e.master], cyc - e.start + 1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < NM; m++) begin
            if (drop[m]) begin
                bus.m_read_in[m]  = 1'b0;
                bus.m_write_in[m] = 1'b0;
            end
        end
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'h0);
        sb_q.delete();
        clear_masters();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_masters();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_masters();
        slave_wait = 0;
        do_reset();
        check_eq("rst_sel", 32'(bus.sel_out), 32'h0);
        check_eq("rst_ready", 32'(bus.m_ready_out), 32'h0);
        check_eq("rst_fault", 32'(bus.m_fault_out), 32'h0);
        check_eq("rst_addr", bus.address_out, 32'h0);
        check_eq("rst_read", 32'(bus.read_out), 32'h0);

        // Zero-wait read by master 0; mask must not leak while write is low.
        issue(0, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 1'b0, 2);
        drain(10);

        // Pointer now at master 1, so it wins a simultaneous request.
        issue(1, 1'b1, 1'b0, 32'h0003_0008, 4'h0, 32'h0, 3, 1'b0, 2);
        issue(0, 1'b1, 1'b0, 32'h0002_0004, 4'h0, 32'h0, 2, 1'b0, 4);
        drain(20);

        // From reset, simultaneous requests alternate 0,1,0,1.
        do_reset();
        repeat (2) begin
            issue(0, 1'b1, 1'b0, 32'h0002_0004, 4'h0, 32'h0, 2, 1'b0, 2);
            issue(1, 1'b1, 1'b0, 32'h0003_0008, 4'h0, 32'h0, 3, 1'b0, 4);
            drain(20);
        end

        slave_wait = 2;
        issue(1, 1'b1, 1'b0, 32'h0003_000C, 4'h0, 32'h0, 3, 1'b0, 4);
        drain(20);

        slave_wait = 0;
        issue(0, 1'b1, 1'b0, 32'h0400_0000, 4'h0, 32'h0, -1, 1'b1, 2);
        drain(10);

        issue(1, 1'b0, 1'b1, 32'h0001_0000, 4'b0001, 32'h0000_00A5, 1, 1'b0, 2);
        drain(10);

        slave_wait = -1;
        issue(1, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 0, 1'b1, 5);
        drain(20);
        check_eq("idle_after_tmo_sel", 32'(bus.sel_out), 32'h0);
        check_eq("idle_after_tmo_ready", 32'(bus.m_ready_out), 32'h0);

        // Leave the pointer at master 1, then abandon a BUSY transfer with reset.
        slave_wait = 0;
        issue(0, 1'b1, 1'b0, 32'h0000_0030, 4'h0, 32'h0, 0, 1'b0, 2);
        drain(10);
        slave_wait = -1;
        bus.m_address_in[0] = 32'h0000_0040;
        bus.m_read_in[0]    = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        bus.m_read_in[0] = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("rst_busy_sel", 32'(bus.sel_out), 32'h0);
        check_eq("rst_busy_ready", 32'(bus.m_ready_out), 32'h0);
        check_eq("rst_busy_fault", 32'(bus.m_fault_out), 32'h0);
        slave_wait = 0;
        issue(0, 1'b1, 1'b0, 32'h0002_0004, 4'h0, 32'h0, 2, 1'b0, 2);
        issue(1, 1'b1, 1'b0, 32'h0003_0008, 4'h0, 32'h0, 3, 1'b0, 4);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
